riscv_perf_dump_ctrl: RTL and testbench



---
 rtl/riscv_perf_dump_ctrl_pkg.sv | 24 ++
 rtl/riscv_perf_dump_ctrl.sv | 164 ++++++++++++++++
 tb/tb_riscv_perf_dump_ctrl.sv | 338 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/riscv_perf_dump_ctrl_pkg.sv
// rtl/riscv_perf_dump_ctrl_pkg.sv - CSR op codes, perf CSR addresses and dump FSM states
package riscv_perf_dump_ctrl_pkg;

  localparam logic [1:0] CSR_OP_NONE  = 2'b00;
  localparam logic [1:0] CSR_OP_WRITE = 2'b01;
  localparam logic [1:0] CSR_OP_SET   = 2'b10;
  localparam logic [1:0] CSR_OP_CLEAR = 2'b11;

  localparam logic [11:0] PERF_PCCR_BASE = 12'h780;
  localparam logic [11:0] PERF_PCCR_ALL  = 12'h79F;
  localparam logic [11:0] PERF_PCMR_ADDR = 12'h7A1;

  typedef enum logic [2:0] {
    PD_IDLE,
    PD_SAVE,
    PD_FREEZE,
    PD_READ,
    PD_WAIT,
    PD_CLEAR,
    PD_RESTORE,
    PD_DONE
  } perf_dump_state_e;

endpackage

// File: rtl/riscv_perf_dump_ctrl.sv
// rtl/riscv_perf_dump_ctrl.sv - snapshots all PCCR counters and streams them out,
// sharing the CSR port with the core (core always wins).
module riscv_perf_dump_ctrl
  import riscv_perf_dump_ctrl_pkg::*;
#(
  parameter int unsigned N_PERF_COUNTERS = 11,
  parameter logic [11:0] PCCR_BASE       = PERF_PCCR_BASE,
  parameter logic [11:0] PCCR_ALL_ADDR   = PERF_PCCR_ALL,
  parameter logic [11:0] PCMR_ADDR       = PERF_PCMR_ADDR
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        core_csr_access_i,
  input  logic [11:0] core_csr_addr_i,
  input  logic [31:0] core_csr_wdata_i,
  input  logic [1:0]  core_csr_op_i,
  output logic [31:0] core_csr_rdata_o,
  output logic        csr_access_o,
  output logic [11:0] csr_addr_o,
  output logic [31:0] csr_wdata_o,
  output logic [1:0]  csr_op_o,
  input  logic [31:0] csr_rdata_i,
  input  logic        dump_req_i,
  input  logic        dump_clear_i,
  output logic        dump_busy_o,
  output logic        dump_done_o,
  output logic        dump_valid_o,
  input  logic        dump_ready_i,
  output logic [4:0]  dump_idx_o,
  output logic [31:0] dump_data_o
);

  localparam logic [4:0] LAST_IDX = 5'(N_PERF_COUNTERS - 1);

  perf_dump_state_e state_q;
  logic [4:0]       idx_q;
  logic             clear_q;
  logic [1:0]       saved_pcmr_q;
  logic             valid_q;
  logic             done_q;
  logic [4:0]       dump_idx_q;
  logic [31:0]      dump_data_q;

  logic             fsm_access;
  logic [11:0]      fsm_addr;
  logic [31:0]      fsm_wdata;
  logic [1:0]       fsm_op;
  logic             grant;

  always_comb begin
    fsm_access = 1'b0;
    fsm_addr   = '0;
    fsm_wdata  = '0;
    fsm_op     = CSR_OP_NONE;
    case (state_q)
      PD_SAVE: begin
        fsm_access = 1'b1;
        fsm_addr   = PCMR_ADDR;
      end
      PD_FREEZE: begin
        fsm_access = 1'b1;
        fsm_addr   = PCMR_ADDR;
        fsm_op     = CSR_OP_WRITE;
      end
      PD_READ: begin
        fsm_access = 1'b1;
        fsm_addr   = PCCR_BASE + {7'b0, idx_q};
      end
      PD_CLEAR: begin
        fsm_access = 1'b1;
        fsm_addr   = PCCR_ALL_ADDR;
        fsm_op     = CSR_OP_WRITE;
      end
      PD_RESTORE: begin
        fsm_access = 1'b1;
        fsm_addr   = PCMR_ADDR;
        fsm_wdata  = {30'b0, saved_pcmr_q};
        fsm_op     = CSR_OP_WRITE;
      end
      default: ;
    endcase
  end

  // The core owns the port whenever it asks; the FSM only sees a grant otherwise.
  assign grant            = ~core_csr_access_i;
  assign csr_access_o     = core_csr_access_i ? 1'b1             : fsm_access;
  assign csr_addr_o       = core_csr_access_i ? core_csr_addr_i  : fsm_addr;
  assign csr_wdata_o      = core_csr_access_i ? core_csr_wdata_i : fsm_wdata;
  assign csr_op_o         = core_csr_access_i ? core_csr_op_i    : fsm_op;
  assign core_csr_rdata_o = csr_rdata_i;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= PD_IDLE;
      idx_q        <= '0;
      clear_q      <= 1'b0;
      saved_pcmr_q <= '0;
      valid_q      <= 1'b0;
      done_q       <= 1'b0;
      dump_idx_q   <= '0;
      dump_data_q  <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        PD_IDLE: begin
          if (dump_req_i) begin
            clear_q <= dump_clear_i;
            idx_q   <= '0;
            state_q <= PD_SAVE;
          end
        end
        PD_SAVE: begin
          if (grant) begin
            saved_pcmr_q <= csr_rdata_i[1:0];
            state_q      <= PD_FREEZE;
          end
        end
        PD_FREEZE: begin
          if (grant) state_q <= PD_READ;
        end
        PD_READ: begin
          if (grant) begin
            dump_data_q <= csr_rdata_i;
            dump_idx_q  <= idx_q;
            valid_q     <= 1'b1;
            state_q     <= PD_WAIT;
          end
        end
        // WAIT issues no access, so a core request does not hold up the handshake.
        PD_WAIT: begin
          if (dump_ready_i) begin
            valid_q <= 1'b0;
            if (idx_q != LAST_IDX) begin
              idx_q   <= idx_q + 5'd1;
              state_q <= PD_READ;
            end else if (clear_q) begin
              state_q <= PD_CLEAR;
            end else begin
              state_q <= PD_RESTORE;
            end
          end
        end
        PD_CLEAR: begin
          if (grant) state_q <= PD_RESTORE;
        end
        PD_RESTORE: begin
          if (grant) begin
            done_q  <= 1'b1;
            state_q <= PD_DONE;
          end
        end
        PD_DONE: state_q <= PD_IDLE;
        default: state_q <= PD_IDLE;
      endcase
    end
  end

  assign dump_busy_o  = (state_q != PD_IDLE);
  assign dump_done_o  = done_q;
  assign dump_valid_o = valid_q;
  assign dump_idx_o   = dump_idx_q;
  assign dump_data_o  = dump_data_q;

endmodule

// File: tb/tb_riscv_perf_dump_ctrl.sv
// tb/tb_riscv_perf_dump_ctrl.sv - bench for riscv_perf_dump_ctrl with a CSR file model
// and a transaction-level expectation of each dump.
module tb_riscv_perf_dump_ctrl;
  import riscv_perf_dump_ctrl_pkg::*;

  localparam int          N       = 11;
  localparam logic [11:0] BASE    = 12'h780;
  localparam logic [11:0] ALL     = 12'h79F;
  localparam logic [11:0] PCMR    = 12'h7A1;
  localparam logic [11:0] SCRATCH = 12'h300;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        core_csr_access_i = 1'b0;
  logic [11:0] core_csr_addr_i = '0;
  logic [31:0] core_csr_wdata_i = '0;
  logic [1:0]  core_csr_op_i = CSR_OP_NONE;
  logic [31:0] core_csr_rdata_o;
  logic        csr_access_o;
  logic [11:0] csr_addr_o;
  logic [31:0] csr_wdata_o;
  logic [1:0]  csr_op_o;
  logic [31:0] csr_rdata_i;
  logic        dump_req_i = 1'b0;
  logic        dump_clear_i = 1'b0;
  logic        dump_busy_o;
  logic        dump_done_o;
  logic        dump_valid_o;
  logic        dump_ready_i = 1'b1;
  logic [4:0]  dump_idx_o;
  logic [31:0] dump_data_o;

  riscv_perf_dump_ctrl #(.N_PERF_COUNTERS(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .core_csr_access_i(core_csr_access_i), .core_csr_addr_i(core_csr_addr_i),
    .core_csr_wdata_i(core_csr_wdata_i), .core_csr_op_i(core_csr_op_i),
    .core_csr_rdata_o(core_csr_rdata_o),
    .csr_access_o(csr_access_o), .csr_addr_o(csr_addr_o), .csr_wdata_o(csr_wdata_o),
    .csr_op_o(csr_op_o), .csr_rdata_i(csr_rdata_i),
    .dump_req_i(dump_req_i), .dump_clear_i(dump_clear_i), .dump_busy_o(dump_busy_o),
    .dump_done_o(dump_done_o), .dump_valid_o(dump_valid_o), .dump_ready_i(dump_ready_i),
    .dump_idx_o(dump_idx_o), .dump_data_o(dump_data_o)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc_cnt = 0;
  int done_cnt = 0;

  task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  // CSR register file model: combinational read, op applied at the clock edge.
  logic [31:0] pccr_mem [N];
  logic [31:0] pcmr_mem = '0;
  logic [31:0] scratch_mem = '0;

  function automatic logic [31:0] apply_op(input logic [31:0] o, input logic [1:0] op, input logic [31:0] w);
    case (op)
      CSR_OP_WRITE: return w;
      CSR_OP_SET:   return o | w;
      CSR_OP_CLEAR: return o & ~w;
      default:      return o;
    endcase
  endfunction

  always @(posedge clk) begin
    cyc_cnt <= cyc_cnt + 1;
    if (csr_access_o) begin
      if (csr_addr_o == ALL) begin
        for (int i = 0; i < N; i++) pccr_mem[i] <= apply_op(pccr_mem[i], csr_op_o, csr_wdata_o);
      end else if (csr_addr_o == PCMR) begin
        pcmr_mem <= apply_op(pcmr_mem, csr_op_o, csr_wdata_o);
      end else if (csr_addr_o == SCRATCH) begin
        scratch_mem <= apply_op(scratch_mem, csr_op_o, csr_wdata_o);
      end else if (csr_addr_o >= BASE && csr_addr_o < BASE + 12'(N)) begin
        pccr_mem[int'(csr_addr_o - BASE)] <= apply_op(pccr_mem[int'(csr_addr_o - BASE)], csr_op_o, csr_wdata_o);
      end
    end
  end

  always_comb begin
    csr_rdata_i = '0;
    if (csr_addr_o == PCMR) csr_rdata_i = pcmr_mem;
    else if (csr_addr_o == SCRATCH) csr_rdata_i = scratch_mem;
    else if (csr_addr_o >= BASE && csr_addr_o < BASE + 12'(N)) csr_rdata_i = pccr_mem[int'(csr_addr_o - BASE)];
  end

  // Expected dump as an ordered list of port accesses plus an ordered list of beats.
  typedef struct packed { logic [11:0] addr; logic [1:0] op; logic [31:0] wdata; } acc_t;
  typedef struct packed { logic [4:0] idx; logic [31:0] data; } beat_t;
  acc_t  exp_acc[$];
  beat_t exp_beat[$];
  bit          m_busy = 1'b0;
  bit          prev_valid = 1'b0, prev_ready = 1'b0, prev_done = 1'b0;
  logic [4:0]  prev_idx = '0;
  logic [31:0] prev_data = '0;

  always @(negedge clk) begin
    acc_t  e;
    beat_t b;
    if (!rst_n) begin
      m_busy = 1'b0;
      exp_acc.delete();
      exp_beat.delete();
      prev_valid = 1'b0;
      prev_done  = 1'b0;
    end else begin
      chk(core_csr_rdata_o == csr_rdata_i, "rdata_pass", core_csr_rdata_o, csr_rdata_i);
      chk(dump_busy_o == m_busy, "busy", 32'(dump_busy_o), 32'(m_busy));
      if (core_csr_access_i) begin
        chk(csr_access_o && csr_addr_o == core_csr_addr_i && csr_wdata_o == core_csr_wdata_i
            && csr_op_o == core_csr_op_i, "core_mirror", {20'b0, csr_addr_o}, {20'b0, core_csr_addr_i});
      end else if (csr_access_o) begin
        if (exp_acc.size() == 0) begin
          chk(1'b0, "unexpected_access", {20'b0, csr_addr_o}, 32'h0);
        end else begin
          e = exp_acc.pop_front();
          chk(csr_addr_o == e.addr && csr_op_o == e.op, "fsm_access",
              {18'b0, csr_op_o, csr_addr_o}, {18'b0, e.op, e.addr});
          if (e.op == CSR_OP_WRITE) chk(csr_wdata_o == e.wdata, "fsm_wdata", csr_wdata_o, e.wdata);
          // The mode value to restore is whatever PCMR held when it was saved.
          if (e.addr == PCMR && e.op == CSR_OP_NONE && exp_acc.size() > 0)
            exp_acc[exp_acc.size()-1].wdata = {30'b0, pcmr_mem[1:0]};
        end
      end
      if (prev_valid && !prev_ready)
        chk(dump_valid_o && dump_idx_o == prev_idx && dump_data_o == prev_data, "stream_hold",
            dump_data_o, prev_data);
      if (dump_valid_o && dump_ready_i) begin
        if (exp_beat.size() == 0) begin
          chk(1'b0, "unexpected_beat", {27'b0, dump_idx_o}, 32'h0);
        end else begin
          b = exp_beat.pop_front();
          chk(dump_idx_o == b.idx, "beat_idx", {27'b0, dump_idx_o}, {27'b0, b.idx});
          chk(dump_data_o == b.data, "beat_data", dump_data_o, b.data);
        end
      end
      if (dump_done_o) begin
        chk(exp_acc.size() == 0 && exp_beat.size() == 0, "done_complete",
            32'(exp_acc.size() + exp_beat.size()), 32'h0);
        chk(!prev_done, "done_one_cycle", 32'(prev_done), 32'h0);
        done_cnt++;
      end
      if (!m_busy && dump_req_i) begin
        m_busy = 1'b1;
        exp_acc.push_back('{PCMR, CSR_OP_NONE, 32'h0});
        exp_acc.push_back('{PCMR, CSR_OP_WRITE, 32'h0});
        for (int i = 0; i < N; i++) begin
          exp_acc.push_back('{BASE + 12'(i), CSR_OP_NONE, 32'h0});
          exp_beat.push_back('{5'(i), pccr_mem[i]});
        end
        if (dump_clear_i) exp_acc.push_back('{ALL, CSR_OP_WRITE, 32'h0});
        exp_acc.push_back('{PCMR, CSR_OP_WRITE, 32'h0});
      end else if (dump_done_o) begin
        m_busy = 1'b0;
      end
      prev_valid = dump_valid_o;
      prev_ready = dump_ready_i;
      prev_idx   = dump_idx_o;
      prev_data  = dump_data_o;
      prev_done  = dump_done_o;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic core_wr(input logic [11:0] a, input logic [31:0] d);
    core_csr_access_i = 1'b1;
    core_csr_addr_i   = a;
    core_csr_wdata_i  = d;
    core_csr_op_i     = CSR_OP_WRITE;
    cyc();
    core_csr_access_i = 1'b0;
    core_csr_op_i     = CSR_OP_NONE;
  endtask

  task automatic preload();
    for (int i = 0; i < N; i++) core_wr(BASE + 12'(i), 32'(100 + i));
    core_wr(PCMR, 32'h3);
  endtask

  int t0;
  task automatic start_dump(input bit clr);
    dump_req_i   = 1'b1;
    dump_clear_i = clr;
    t0 = cyc_cnt;
    cyc();
    dump_req_i   = 1'b0;
    dump_clear_i = 1'b0;
  endtask

  task automatic wait_done(input int max, output int lat);
    while (!dump_done_o && (cyc_cnt - t0) < max) cyc();
    chk(dump_done_o, "done_timeout", 32'(dump_done_o), 32'h1);
    lat = cyc_cnt - t0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat, held, d0, k;
    cyc(); cyc(); cyc();
    chk(!dump_busy_o && !dump_valid_o && !dump_done_o, "reset_flags",
        {29'b0, dump_busy_o, dump_valid_o, dump_done_o}, 32'h0);
    chk(dump_idx_o == 5'd0 && dump_data_o == 32'h0, "reset_beat", dump_data_o, 32'h0);
    chk(!csr_access_o, "reset_no_access", 32'(csr_access_o), 32'h0);
    rst_n = 1'b1;
    cyc();

    preload();
    start_dump(1'b0);
    wait_done(100, lat);
    chk(lat == 2 * N + 4, "latency_plain", 32'(lat), 32'(2 * N + 4));
    cyc();
    chk(pcmr_mem == 32'h3, "pcmr_restored", pcmr_mem, 32'h3);
    for (int i = 0; i < N; i++) chk(pccr_mem[i] == 32'(100 + i), "pccr_kept", pccr_mem[i], 32'(100 + i));

    start_dump(1'b1);
    wait_done(100, lat);
    chk(lat == 2 * N + 5, "latency_clear", 32'(lat), 32'(2 * N + 5));
    cyc();
    for (int i = 0; i < N; i++) chk(pccr_mem[i] == 32'h0, "pccr_cleared", pccr_mem[i], 32'h0);
    chk(pcmr_mem == 32'h3, "pcmr_after_clear", pcmr_mem, 32'h3);

    preload();
    held = 0;
    start_dump(1'b0);
    while (!dump_done_o && (cyc_cnt - t0) < 200) begin
      if (dump_valid_o && dump_idx_o == 5'd3 && held < 5) begin
        chk(dump_data_o == 32'd103, "stall_beat3_data", dump_data_o, 32'd103);
        dump_ready_i = 1'b0;
        held++;
      end else begin
        dump_ready_i = 1'b1;
      end
      cyc();
    end
    dump_ready_i = 1'b1;
    chk(dump_done_o, "done_timeout", 32'(dump_done_o), 32'h1);
    chk(held == 5, "ready_low_cycles", 32'(held), 32'd5);
    chk(cyc_cnt - t0 == 2 * N + 9, "latency_backpressure", 32'(cyc_cnt - t0), 32'(2 * N + 9));
    cyc();

    start_dump(1'b0);
    k = 0;
    while (!(csr_access_o && csr_addr_o == BASE + 12'd4) && k < 50) begin cyc(); k++; end
    chk(k < 50, "reach_read4", 32'(k), 32'd0);
    core_csr_access_i = 1'b1; core_csr_addr_i = BASE + 12'd7; core_csr_op_i = CSR_OP_NONE;
    #1;
    chk(csr_addr_o == 12'h787, "core_addr_through", {20'b0, csr_addr_o}, 32'h787);
    chk(core_csr_rdata_o == 32'd107, "core_rdata_pccr", core_csr_rdata_o, 32'd107);
    cyc();
    core_csr_addr_i = SCRATCH; core_csr_wdata_i = 32'hCAFE_0042; core_csr_op_i = CSR_OP_WRITE;
    #1;
    chk(csr_op_o == CSR_OP_WRITE && csr_wdata_o == 32'hCAFE_0042, "core_wdata_through", csr_wdata_o, 32'hCAFE_0042);
    cyc();
    core_csr_op_i = CSR_OP_NONE;
    #1;
    chk(core_csr_rdata_o == 32'hCAFE_0042, "core_rdata_scratch", core_csr_rdata_o, 32'hCAFE_0042);
    cyc();
    core_csr_access_i = 1'b0;
    #1;
    chk(csr_access_o && csr_addr_o == 12'h784, "resume_read4", {20'b0, csr_addr_o}, 32'h784);
    wait_done(100, lat);
    chk(lat == 2 * N + 7, "latency_core_stall", 32'(lat), 32'(2 * N + 7));
    cyc();

    d0 = done_cnt;
    start_dump(1'b0);
    cyc(); cyc(); cyc();
    dump_req_i = 1'b1; cyc(); cyc(); dump_req_i = 1'b0;
    for (int i = 0; i < 60; i++) cyc();
    chk(done_cnt - d0 == 1, "single_done", 32'(done_cnt - d0), 32'd1);
    chk(!dump_busy_o, "idle_after_ignored_req", 32'(dump_busy_o), 32'h0);

    dump_ready_i = 1'b0;
    start_dump(1'b0);
    k = 0;
    while (!dump_valid_o && k < 50) begin cyc(); k++; end
    chk(dump_valid_o, "reach_wait", 32'(dump_valid_o), 32'h1);
    rst_n = 1'b0;
    cyc();
    chk(!dump_busy_o && !dump_valid_o && !csr_access_o, "reset_in_wait",
        {29'b0, dump_busy_o, dump_valid_o, csr_access_o}, 32'h0);
    rst_n = 1'b1;
    dump_ready_i = 1'b1;
    cyc();
    start_dump(1'b0);
    wait_done(100, lat);
    chk(lat == 2 * N + 4, "latency_after_reset", 32'(lat), 32'(2 * N + 4));
    cyc();
    chk(pcmr_mem == 32'h0, "pcmr_not_restored_by_abort", pcmr_mem, 32'h0);
    core_wr(PCMR, 32'h3);

    for (int it = 0; it < 15; it++) begin
      if ($urandom_range(0, 1) == 1)
        for (int i = 0; i < N; i++) core_wr(BASE + 12'(i), $urandom);
      start_dump(1'($urandom_range(0, 1)));
      while (!dump_done_o && (cyc_cnt - t0) < 600) begin
        dump_ready_i = ($urandom_range(0, 9) < 7);
        dump_req_i   = ($urandom_range(0, 9) == 0);
        dump_clear_i = 1'($urandom_range(0, 1));
        core_csr_access_i = ($urandom_range(0, 4) == 0);
        core_csr_wdata_i  = $urandom;
        case ($urandom_range(0, 2))
          0: begin core_csr_addr_i = SCRATCH; core_csr_op_i = 2'($urandom_range(0, 3)); end
          1: begin core_csr_addr_i = PCMR;    core_csr_op_i = 2'($urandom_range(0, 3)); end
          default: begin core_csr_addr_i = BASE + 12'($urandom_range(0, N - 1)); core_csr_op_i = CSR_OP_NONE; end
        endcase
        cyc();
      end
      chk(dump_done_o, "random_done_timeout", 32'(dump_done_o), 32'h1);
      core_csr_access_i = 1'b0; core_csr_op_i = CSR_OP_NONE;
      dump_req_i = 1'b0; dump_clear_i = 1'b0; dump_ready_i = 1'b1;
      cyc();
    end

    cyc();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
